// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and requester encoding for the write-back arbiter
package wb_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back request handshakes and register-file write port
interface regfile_wb_arbiter_if;
    import wb_pkg::*;

    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;

    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;

    logic              Wen;
    logic [ADDR_W-1:0] Rd_addr;
    logic [DATA_W-1:0] write_data;

    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output a_ready, b_ready,
        output Wen, Rd_addr, write_data
    );

    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  a_ready, b_ready,
        input  Wen, Rd_addr, write_data
    );

endinterface

// File: rtl/wb_hold_slot.sv
// rtl/wb_hold_slot.sv - one-entry write-back buffer for a single requester
module wb_hold_slot
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              grant,
    output logic              hv,
    output logic [ADDR_W-1:0] hrd,
    output logic [DATA_W-1:0] hdata
);

    logic load;

    // A granted entry leaves this cycle, so the slot can refill at the same edge
    assign in_ready = !rst && (!hv || grant);
    assign load     = in_valid && in_ready;

    // Slot contents: load wins over the grant-driven clear
    always_ff @(posedge clk) begin
        if (rst) begin
            hv    <= 1'b0;
            hrd   <= '0;
            hdata <= '0;
        end else if (load) begin
            hv    <= 1'b1;
            hrd   <= in_rd;
            hdata <= in_data;
        end else if (grant) begin
            hv    <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester write-back arbiter with pending-register scoreboard
module regfile_wb_arbiter
    import wb_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   Rs1_addr,
    input  logic [ADDR_W-1:0]   Rs2_addr,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending,
    regfile_wb_arbiter_if.slave wb
);

    logic              hv_a, hv_b;
    logic [ADDR_W-1:0] hrd_a, hrd_b;
    logic [DATA_W-1:0] hdata_a, hdata_b;
    logic              grant_a, grant_b;
    logic              any_grant, commit;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    req_e              last_grant;
    logic [NUM_REGS-1:0] pending_next;

    wb_hold_slot u_slot_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (wb.a_valid),
        .in_rd    (wb.a_rd),
        .in_data  (wb.a_data),
        .in_ready (wb.a_ready),
        .grant    (grant_a),
        .hv       (hv_a),
        .hrd      (hrd_a),
        .hdata    (hdata_a)
    );

    wb_hold_slot u_slot_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (wb.b_valid),
        .in_rd    (wb.b_rd),
        .in_data  (wb.b_data),
        .in_ready (wb.b_ready),
        .grant    (grant_b),
        .hv       (hv_b),
        .hrd      (hrd_b),
        .hdata    (hdata_b)
    );

    // Round-robin only matters when both slots hold an entry
    always_comb begin
        grant_a   = hv_a && (!hv_b || (last_grant == REQ_B));
        grant_b   = hv_b && (!hv_a || (last_grant == REQ_A));
        any_grant = grant_a || grant_b;
        sel_rd    = grant_a ? hrd_a   : hrd_b;
        sel_data  = grant_a ? hdata_a : hdata_b;
        commit    = any_grant && (sel_rd != '0);
    end

    // Fairness pointer moves only on a contested grant
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_B;
        end else if (hv_a && hv_b) begin
            last_grant <= grant_a ? REQ_A : REQ_B;
        end
    end

    // Register-file write port; x0 grants and idle cycles hold address and data
    always_ff @(posedge clk) begin
        if (rst) begin
            wb.Wen        <= 1'b0;
            wb.Rd_addr    <= '0;
            wb.write_data <= '0;
        end else begin
            wb.Wen <= commit;
            if (commit) begin
                wb.Rd_addr    <= sel_rd;
                wb.write_data <= sel_data;
            end
        end
    end

    // Scoreboard update: a new issue to the same register outranks the retiring write
    always_comb begin
        pending_next = pending;
        if (commit) begin
            pending_next[sel_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Hazard flag to decode; pending[0] is held at zero so x0 never stalls
    always_comb begin
        stall = pending[Rs1_addr] | pending[Rs2_addr] | (issue_valid && pending[issue_rd]);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import wb_pkg::*;

    logic                clk;
    logic                rst;
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_rd;
    logic [ADDR_W-1:0]   Rs1_addr;
    logic [ADDR_W-1:0]   Rs2_addr;
    logic                stall;
    logic [NUM_REGS-1:0] pending;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter_if wb ();

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .Rs1_addr    (Rs1_addr),
        .Rs2_addr    (Rs2_addr),
        .stall       (stall),
        .pending     (pending),
        .wb          (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (wb.a_ready !== 1'b0 || wb.b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low a=%b b=%b exp 0 0", wb.a_ready, wb.b_ready); end
        checks++; if (wb.Wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", wb.Wen); end
        checks++; if (wb.Rd_addr !== 5'd0 || wb.write_data !== 64'd0) begin errors++; $display("FAIL reset_addr_data got %0d %h exp 0 0", wb.Rd_addr, wb.write_data); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending got %h exp 0", pending); end
        rst = 1'b0;
        #1;
        checks++; if (wb.a_ready !== 1'b1 || wb.b_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high a=%b b=%b exp 1 1", wb.a_ready, wb.b_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    endtask

    task automatic test_uncontested();
        issue_valid = 1'b1; issue_rd = 5'd5;
        step();
        issue_valid = 1'b0; Rs1_addr = 5'd5;
        #1;
        checks++; if (pending !== 32'h0000_0020) begin errors++; $display("FAIL unc_pending_set got %h exp 00000020", pending); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL unc_stall got %b exp 1", stall); end
        wb.a_valid = 1'b1; wb.a_rd = 5'd5; wb.a_data = 64'h0123_4567_89AB_CDEF;
        step();
        wb.a_valid = 1'b0;
        #1;
        checks++; if (wb.Wen !== 1'b0) begin errors++; $display("FAIL unc_early_wen got %b exp 0", wb.Wen); end
        step();
        checks++; if (wb.Wen !== 1'b1 || wb.Rd_addr !== 5'd5) begin errors++; $display("FAIL unc_commit wen=%b rd=%0d exp 1 5", wb.Wen, wb.Rd_addr); end
        checks++; if (wb.write_data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL unc_data got %h exp 0123456789abcdef", wb.write_data); end
        checks++; if (pending !== 32'd0 || stall !== 1'b0) begin errors++; $display("FAIL unc_clear pending=%h stall=%b exp 0 0", pending, stall); end
        step();
        checks++; if (wb.Wen !== 1'b0) begin errors++; $display("FAIL unc_pulse got %b exp 0", wb.Wen); end
        Rs1_addr = 5'd0;
    endtask

    task automatic test_contention();
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        issue_rd = 5'd4;
        step();
        issue_valid = 1'b0;
        wb.a_valid = 1'b1; wb.a_rd = 5'd3; wb.a_data = 64'h33;
        wb.b_valid = 1'b1; wb.b_rd = 5'd4; wb.b_data = 64'h44;
        #1;
        checks++; if (pending !== 32'h0000_0018) begin errors++; $display("FAIL cont_pending got %h exp 00000018", pending); end
        step();
        wb.a_valid = 1'b0; wb.b_valid = 1'b0;
        #1;
        checks++; if (wb.a_ready !== 1'b1 || wb.b_ready !== 1'b0) begin errors++; $display("FAIL cont1_ready a=%b b=%b exp 1 0", wb.a_ready, wb.b_ready); end
        step();
        checks++; if (wb.Wen !== 1'b1 || wb.Rd_addr !== 5'd3 || wb.write_data !== 64'h33) begin errors++; $display("FAIL cont1_first wen=%b rd=%0d data=%h exp 1 3 33", wb.Wen, wb.Rd_addr, wb.write_data); end
        checks++; if (pending !== 32'h0000_0010) begin errors++; $display("FAIL cont1_pending got %h exp 00000010", pending); end
        step();
        checks++; if (wb.Wen !== 1'b1 || wb.Rd_addr !== 5'd4 || wb.write_data !== 64'h44) begin errors++; $display("FAIL cont1_second wen=%b rd=%0d data=%h exp 1 4 44", wb.Wen, wb.Rd_addr, wb.write_data); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL cont1_pending_end got %h exp 0", pending); end
        step();
        wb.a_valid = 1'b1; wb.b_valid = 1'b1;
        step();
        wb.a_valid = 1'b0; wb.b_valid = 1'b0;
        #1;
        checks++; if (wb.a_ready !== 1'b0 || wb.b_ready !== 1'b1) begin errors++; $display("FAIL cont2_ready a=%b b=%b exp 0 1", wb.a_ready, wb.b_ready); end
        step();
        checks++; if (wb.Wen !== 1'b1 || wb.Rd_addr !== 5'd4) begin errors++; $display("FAIL cont2_first wen=%b rd=%0d exp 1 4", wb.Wen, wb.Rd_addr); end
        step();
        checks++; if (wb.Wen !== 1'b1 || wb.Rd_addr !== 5'd3) begin errors++; $display("FAIL cont2_second wen=%b rd=%0d exp 1 3", wb.Wen, wb.Rd_addr); end
        step();
    endtask

    task automatic test_stream();
        int  ka = 0;
        int  kb = 0;
        int  n = 0;
        int  exp_rd;
        bit  started = 1'b0;
        bit  ta, tb;
        for (int c = 0; c < 20; c++) begin
            wb.a_valid = (c < 8); wb.a_rd = 5'(8 + ka);  wb.a_data = 64'h1000 + 64'(8 + ka);
            wb.b_valid = (c < 8); wb.b_rd = 5'(16 + kb); wb.b_data = 64'h1000 + 64'(16 + kb);
            #1;
            if (c == 0) begin
                checks++; if (wb.a_ready !== 1'b1 || wb.b_ready !== 1'b1) begin errors++; $display("FAIL stream_ready c=0 a=%b b=%b exp 1 1", wb.a_ready, wb.b_ready); end
            end else if (c < 8) begin
                checks++; if (wb.a_ready !== 1'(c % 2) || wb.b_ready !== 1'((c + 1) % 2)) begin errors++; $display("FAIL stream_ready c=%0d a=%b b=%b exp %0d %0d", c, wb.a_ready, wb.b_ready, c % 2, (c + 1) % 2); end
            end
            if (wb.Wen === 1'b1) begin
                exp_rd = (n % 2 == 0) ? 8 + n / 2 : 16 + n / 2;
                checks++; if (int'(wb.Rd_addr) != exp_rd || wb.write_data !== 64'h1000 + 64'(exp_rd)) begin errors++; $display("FAIL stream_commit n=%0d rd=%0d data=%h exp %0d %h", n, wb.Rd_addr, wb.write_data, exp_rd, 64'h1000 + 64'(exp_rd)); end
                n++;
                started = 1'b1;
            end else if (started && n < 9) begin
                checks++; errors++; $display("FAIL stream_wen_gap c=%0d got 0 exp 1", c);
            end
            ta = wb.a_valid && wb.a_ready;
            tb = wb.b_valid && wb.b_ready;
            step();
            if (ta) ka++;
            if (tb) kb++;
        end
        checks++; if (n != 9 || ka != 5 || kb != 4) begin errors++; $display("FAIL stream_count commits=%0d a=%0d b=%0d exp 9 5 4", n, ka, kb); end
    endtask

    task automatic test_x0();
        wb.a_valid = 1'b1; wb.a_rd = 5'd0; wb.a_data = 64'hFF;
        step();
        wb.a_valid = 1'b0;
        #1;
        checks++; if (wb.a_ready !== 1'b1) begin errors++; $display("FAIL x0_ready_grant got %b exp 1", wb.a_ready); end
        step();
        checks++; if (wb.Wen !== 1'b0) begin errors++; $display("FAIL x0_wen got %b exp 0", wb.Wen); end
        checks++; if (wb.Rd_addr !== 5'd12 || wb.write_data !== 64'h100C) begin errors++; $display("FAIL x0_hold rd=%0d data=%h exp 12 100c", wb.Rd_addr, wb.write_data); end
        checks++; if (pending !== 32'd0 || wb.a_ready !== 1'b1) begin errors++; $display("FAIL x0_after pending=%h ready=%b exp 0 1", pending, wb.a_ready); end
    endtask

    task automatic test_same_edge();
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        wb.a_valid = 1'b1; wb.a_rd = 5'd7; wb.a_data = 64'h71;
        step();
        wb.a_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        #1;
        checks++; if (wb.Wen !== 1'b1 || wb.Rd_addr !== 5'd7 || wb.write_data !== 64'h71) begin errors++; $display("FAIL same_first wen=%b rd=%0d data=%h exp 1 7 71", wb.Wen, wb.Rd_addr, wb.write_data); end
        checks++; if (pending !== 32'h0000_0080) begin errors++; $display("FAIL same_set_wins got %h exp 00000080", pending); end
        wb.a_valid = 1'b1; wb.a_data = 64'h72;
        step();
        wb.a_valid = 1'b0;
        #1;
        checks++; if (pending !== 32'h0000_0080) begin errors++; $display("FAIL same_held got %h exp 00000080", pending); end
        step();
        checks++; if (wb.Wen !== 1'b1 || wb.write_data !== 64'h72 || pending !== 32'd0) begin errors++; $display("FAIL same_second wen=%b data=%h pending=%h exp 1 72 0", wb.Wen, wb.write_data, pending); end
        step();
    endtask

    task automatic test_reset_mid();
        issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        Rs1_addr = 5'd7; Rs2_addr = 5'd4;
        #1;
        checks++; if (pending !== 32'h0000_0090 || stall !== 1'b1) begin errors++; $display("FAIL mid_setup pending=%h stall=%b exp 00000090 1", pending, stall); end
        wb.a_valid = 1'b1; wb.a_rd = 5'd4; wb.a_data = 64'hAA;
        wb.b_valid = 1'b1; wb.b_rd = 5'd7; wb.b_data = 64'hBB;
        step();
        wb.a_valid = 1'b0; wb.b_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (wb.a_ready !== 1'b0 || wb.b_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_rst a=%b b=%b exp 0 0", wb.a_ready, wb.b_ready); end
        step();
        checks++; if (wb.Wen !== 1'b0 || wb.Rd_addr !== 5'd0 || wb.write_data !== 64'd0 || pending !== 32'd0) begin errors++; $display("FAIL mid_outputs wen=%b rd=%0d data=%h pending=%h exp all 0", wb.Wen, wb.Rd_addr, wb.write_data, pending); end
        rst = 1'b0;
        #1;
        checks++; if (wb.a_ready !== 1'b1 || wb.b_ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL mid_release a=%b b=%b stall=%b exp 1 1 0", wb.a_ready, wb.b_ready, stall); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (wb.Wen !== 1'b0) begin errors++; $display("FAIL mid_no_wen i=%0d got %b exp 0", i, wb.Wen); end
        end
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_rd = '0; Rs1_addr = '0; Rs2_addr = '0;
        wb.a_valid = 1'b0; wb.a_rd = '0; wb.a_data = '0;
        wb.b_valid = 1'b0; wb.b_rd = '0; wb.b_data = '0;
        test_reset();
        test_uncontested();
        test_contention();
        test_stream();
        test_x0();
        test_same_edge();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
